// File: rtl/t5_bus_arb.sv
// t5_bus_arb: arbitrates an instruction port and a data port onto one shared
// memory bus, alternating priority on contention, with a per-transaction timeout.
module t5_bus_arb #(
  parameter int unsigned TMO = 16
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic [29:0] iwb_adr,
  input  logic        iwb_stb,
  input  logic        iwb_wre,
  input  logic [3:0]  iwb_sel,
  output logic        iwb_ack,
  output logic [31:0] iwb_dti,
  input  logic [29:0] dwb_adr,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  input  logic [3:0]  dwb_sel,
  input  logic [31:0] dwb_dto,
  output logic        dwb_ack,
  output logic [31:0] dwb_dti,
  output logic [29:0] mwb_adr,
  output logic        mwb_stb,
  output logic        mwb_wre,
  output logic [3:0]  mwb_sel,
  output logic [31:0] mwb_dto,
  input  logic        mwb_ack,
  input  logic [31:0] mwb_dti,
  output logic        merr,
  output logic        mbusy
);

  // state | meaning
  // IDLE  | no grant; arbitrate on the next edge
  // IGNT  | instruction port owns the memory bus
  // DGNT  | data port owns the memory bus
  typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TMO - 1);

  state_t     state;
  logic       last_d;
  logic [7:0] wait_cnt;
  logic       granted;
  logic       timeout;
  logic       done;

  assign iwb_dti = mwb_dti;
  assign dwb_dti = mwb_dti;

  // Reset wins over a memory ack landing in the same cycle: no ack, no error.
  always_comb begin
    granted = (state != IDLE);
    timeout = granted && (wait_cnt == WAIT_LAST) && !mwb_ack;
    done    = granted && (mwb_ack || timeout);
    iwb_ack = done && (state == IGNT) && !srst;
    dwb_ack = done && (state == DGNT) && !srst;
    merr    = timeout && !srst;

    mwb_stb = granted;
    mwb_adr = '0;
    mwb_wre = 1'b0;
    mwb_sel = '0;
    mwb_dto = '0;
    case (state)
      IGNT: begin
        mwb_adr = iwb_adr;
        mwb_wre = iwb_wre;
        mwb_sel = iwb_sel;
      end
      DGNT: begin
        mwb_adr = dwb_adr;
        mwb_wre = dwb_wre;
        mwb_sel = dwb_sel;
        mwb_dto = dwb_dto;
      end
      default: ;
    endcase
  end

  // last_d records who was served last (ack or timeout), so the other side wins a tie.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wait_cnt <= '0;
      mbusy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dwb_stb && (!iwb_stb || !last_d)) begin
            state <= DGNT;
            mbusy <= 1'b1;
          end else if (iwb_stb) begin
            state <= IGNT;
            mbusy <= 1'b1;
          end
        end
        IGNT, DGNT: begin
          if (done) begin
            state  <= IDLE;
            mbusy  <= 1'b0;
            last_d <= (state == DGNT);
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          mbusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t5_bus_arb.sv
// tb_t5_bus_arb: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbiter.
module tb_t5_bus_arb;
  localparam int TMO = 16;

  logic        sclk = 1'b0;
  logic        srst;
  logic [29:0] iwb_adr, dwb_adr, mwb_adr;
  logic        iwb_stb, iwb_wre, dwb_stb, dwb_wre;
  logic [3:0]  iwb_sel, dwb_sel, mwb_sel;
  logic        iwb_ack, dwb_ack, mwb_stb, mwb_wre, mwb_ack, merr, mbusy;
  logic [31:0] iwb_dti, dwb_dti, dwb_dto, mwb_dto, mwb_dti;

  int n_pass = 0;
  int n_total = 0;

  // model: m_grant 0 = none, 1 = instruction, 2 = data
  int m_grant = 0;
  int m_wait = 0;
  bit m_last_d = 1'b0;

  t5_bus_arb #(.TMO(TMO)) dut (
    .sclk(sclk), .srst(srst),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
    .iwb_ack(iwb_ack), .iwb_dti(iwb_dti),
    .dwb_adr(dwb_adr), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel),
    .dwb_dto(dwb_dto), .dwb_ack(dwb_ack), .dwb_dti(dwb_dti),
    .mwb_adr(mwb_adr), .mwb_stb(mwb_stb), .mwb_wre(mwb_wre), .mwb_sel(mwb_sel),
    .mwb_dto(mwb_dto), .mwb_ack(mwb_ack), .mwb_dti(mwb_dti),
    .merr(merr), .mbusy(mbusy)
  );

  always #5 sclk = ~sclk;

  // A transaction ends when memory acks or when TMO granted cycles have elapsed.
  always @(posedge sclk) begin
    if (srst) begin
      m_grant = 0; m_wait = 0; m_last_d = 1'b0;
    end else if (m_grant == 0) begin
      m_wait = 0;
      if (dwb_stb && iwb_stb) m_grant = m_last_d ? 1 : 2;
      else if (dwb_stb)       m_grant = 2;
      else if (iwb_stb)       m_grant = 1;
    end else if (mwb_ack || m_wait == TMO - 1) begin
      m_last_d = (m_grant == 2);
      m_grant = 0;
    end else begin
      m_wait++;
    end
  end

  task automatic next_cycle();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; iwb_stb = 1'b1; dwb_stb = 1'b1; mwb_ack = 1'b1;
    next_cycle();
    @(negedge sclk);
    n_total++; if (mbusy !== 1'b0) $display("FAIL rst_mbusy got %b want 0", mbusy); else n_pass++;
    n_total++; if (mwb_stb !== 1'b0) $display("FAIL rst_mwb_stb got %b want 0", mwb_stb); else n_pass++;
    n_total++; if ({iwb_ack, dwb_ack, merr} !== 3'b000) $display("FAIL rst_acks got %b want 000", {iwb_ack, dwb_ack, merr}); else n_pass++;
    next_cycle();
    srst = 1'b0; iwb_stb = 1'b0; dwb_stb = 1'b0; mwb_ack = 1'b0;
    next_cycle();
    @(negedge sclk);
    n_total++; if ({mwb_stb, iwb_ack, dwb_ack, merr, mbusy} !== 5'b0) $display("FAIL post_rst got %b want 00000", {mwb_stb, iwb_ack, dwb_ack, merr, mbusy}); else n_pass++;
  endtask

  task automatic test_idle_ack();
    mwb_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge sclk);
      n_total++; if ({mbusy, iwb_ack, dwb_ack} !== 3'b000) $display("FAIL idle_ack c%0d got %b want 000", c, {mbusy, iwb_ack, dwb_ack}); else n_pass++;
    end
    mwb_ack = 1'b0;
    next_cycle();
  endtask

  task automatic test_ifetch();
    iwb_adr = 30'h0000_0040; iwb_sel = 4'hF; iwb_wre = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      iwb_stb = (c == 0);
      mwb_ack = (c == 3);
      @(negedge sclk);
      n_total++; if (mbusy !== (c >= 1 && c <= 3)) $display("FAIL ifetch_busy c%0d got %b", c, mbusy); else n_pass++;
      n_total++; if (mwb_adr !== ((c >= 1 && c <= 3) ? 30'h40 : 30'h0)) $display("FAIL ifetch_adr c%0d got %h", c, mwb_adr); else n_pass++;
      n_total++; if ({iwb_ack, dwb_ack} !== {1'(c == 3), 1'b0}) $display("FAIL ifetch_ack c%0d got %b want %b0", c, {iwb_ack, dwb_ack}, c == 3); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_alternate();
    for (int c = 0; c <= 8; c++) begin
      iwb_stb = (c < 8); dwb_stb = (c < 8); mwb_ack = (c < 8);
      @(negedge sclk);
      n_total++; if (mbusy !== 1'(c % 2)) $display("FAIL alt_busy c%0d got %b want %0d", c, mbusy, c % 2); else n_pass++;
      n_total++; if (dwb_ack !== (c % 4 == 1)) $display("FAIL alt_dack c%0d got %b", c, dwb_ack); else n_pass++;
      n_total++; if (iwb_ack !== (c % 4 == 3)) $display("FAIL alt_iack c%0d got %b", c, iwb_ack); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_write();
    dwb_adr = 30'h1234; dwb_wre = 1'b1; dwb_dto = 32'hDEAD_BEEF; dwb_sel = 4'hF;
    for (int c = 0; c <= 5; c++) begin
      dwb_stb = (c == 0);
      mwb_ack = (c == 4);
      @(negedge sclk);
      if (c >= 1 && c <= 4) begin
        n_total++; if (mwb_dto !== 32'hDEAD_BEEF) $display("FAIL wr_dto c%0d got %h want deadbeef", c, mwb_dto); else n_pass++;
        n_total++; if ({mwb_wre, mwb_sel} !== 5'h1F) $display("FAIL wr_wre_sel c%0d got %b want 11111", c, {mwb_wre, mwb_sel}); else n_pass++;
      end else begin
        n_total++; if ({mwb_dto, mwb_wre, mbusy} !== 34'h0) $display("FAIL wr_idle c%0d got dto=%h wre=%b busy=%b want 0", c, mwb_dto, mwb_wre, mbusy); else n_pass++;
      end
      n_total++; if (dwb_ack !== (c == 4)) $display("FAIL wr_ack c%0d got %b", c, dwb_ack); else n_pass++;
      next_cycle();
    end
    dwb_wre = 1'b0; dwb_dto = 32'h1234_5678;
  endtask

  task automatic test_timeout();
    mwb_ack = 1'b0;
    for (int c = 0; c <= TMO + 1; c++) begin
      iwb_stb = (c == 0);
      @(negedge sclk);
      n_total++; if ({iwb_ack, merr} !== {2{1'(c == TMO)}}) $display("FAIL tmo_ack_err c%0d got %b", c, {iwb_ack, merr}); else n_pass++;
      n_total++; if (mbusy !== (c >= 1 && c <= TMO)) $display("FAIL tmo_busy c%0d got %b", c, mbusy); else n_pass++;
      if (mbusy) begin
        n_total++; if (mwb_dto !== 32'h0) $display("FAIL tmo_idto c%0d got %h want 0", c, mwb_dto); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_ack_timeout();
    for (int c = 0; c <= TMO + 1; c++) begin
      dwb_stb = (c == 0);
      mwb_ack = (c == TMO);
      @(negedge sclk);
      n_total++; if ({dwb_ack, merr} !== {1'(c == TMO), 1'b0}) $display("FAIL ack_tmo c%0d got %b", c, {dwb_ack, merr}); else n_pass++;
      next_cycle();
    end
    mwb_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 3; c++) begin
      dwb_stb = (c == 0);
      srst = (c == 2);
      mwb_ack = (c == 2);
      @(negedge sclk);
      if (c == 2) begin
        n_total++; if (dwb_ack !== 1'b0) $display("FAIL rmid_ack got %b want 0", dwb_ack); else n_pass++;
      end
      if (c == 3) begin
        n_total++; if ({mwb_stb, mbusy, dwb_ack} !== 3'b000) $display("FAIL rmid_after got %b want 000", {mwb_stb, mbusy, dwb_ack}); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int ack_pct = 50;
    logic        exp_ack, exp_err;
    logic [29:0] exp_adr;
    logic [31:0] exp_dto;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) ack_pct = ((c / 50) % 3 == 0) ? 0 : int'($urandom_range(10, 80));
      srst    = ($urandom_range(0, 99) == 0);
      iwb_stb = $urandom_range(0, 1); dwb_stb = $urandom_range(0, 1);
      iwb_adr = 30'($urandom); dwb_adr = 30'($urandom);
      iwb_wre = $urandom_range(0, 1); dwb_wre = $urandom_range(0, 1);
      iwb_sel = 4'($urandom); dwb_sel = 4'($urandom);
      dwb_dto = $urandom; mwb_dti = $urandom;
      mwb_ack = ($urandom_range(0, 99) < ack_pct);
      @(negedge sclk);
      exp_ack = !srst && m_grant != 0 && (mwb_ack || m_wait == TMO - 1);
      exp_err = !srst && m_grant != 0 && !mwb_ack && m_wait == TMO - 1;
      exp_adr = (m_grant == 1) ? iwb_adr : (m_grant == 2) ? dwb_adr : 30'h0;
      exp_dto = (m_grant == 2) ? dwb_dto : 32'h0;
      n_total++; if ({mbusy, mwb_stb} !== {2{1'(m_grant != 0)}}) $display("FAIL rnd_busy c%0d got %b grant %0d", c, {mbusy, mwb_stb}, m_grant); else n_pass++;
      n_total++; if (iwb_ack !== (exp_ack && m_grant == 1)) $display("FAIL rnd_iack c%0d got %b", c, iwb_ack); else n_pass++;
      n_total++; if (dwb_ack !== (exp_ack && m_grant == 2)) $display("FAIL rnd_dack c%0d got %b", c, dwb_ack); else n_pass++;
      n_total++; if (merr !== exp_err) $display("FAIL rnd_merr c%0d got %b want %b", c, merr, exp_err); else n_pass++;
      n_total++; if (mwb_adr !== exp_adr) $display("FAIL rnd_adr c%0d got %h want %h", c, mwb_adr, exp_adr); else n_pass++;
      n_total++; if (mwb_dto !== exp_dto) $display("FAIL rnd_dto c%0d got %h want %h", c, mwb_dto, exp_dto); else n_pass++;
      n_total++; if ({iwb_dti, dwb_dti} !== {2{mwb_dti}}) $display("FAIL rnd_dti c%0d got %h/%h want %h", c, iwb_dti, dwb_dti, mwb_dti); else n_pass++;
      next_cycle();
    end
    srst = 1'b0; iwb_stb = 1'b0; dwb_stb = 1'b0; mwb_ack = 1'b0;
  endtask

  initial begin
    srst = 1'b1; iwb_adr = '0; iwb_stb = 1'b0; iwb_wre = 1'b0; iwb_sel = '0;
    dwb_adr = '0; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = '0; dwb_dto = '0;
    mwb_ack = 1'b0; mwb_dti = 32'hCAFE_0001;
    test_reset();
    test_idle_ack();
    test_ifetch();
    test_alternate();
    test_write();
    test_timeout();
    test_ack_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
